// File: rtl/cbus_axi_bridge_if.sv
// cbus_axi_bridge_if: AXI3 AR/R/AW/W/B channel bundle between the bridge (master) and a slave
interface cbus_axi_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 4,
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid, awid, wid, rid;
  logic [31:0] araddr, awaddr;
  logic [LEN_WIDTH-1:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache;
  logic arvalid, arready, awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast, wvalid, wready, rlast, rvalid, rready, bvalid, bready;
  modport master(
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input wready,
    input bresp, bvalid,
    output bready
  );
  modport slave(
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input rready,
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input bready
  );
endinterface

// File: rtl/cbus_axi_bridge.sv
// cbus_axi_bridge: CBus-to-AXI3 master bridge, one transaction outstanding, per-beat CBus handshake.
// Define CBUS_AXI_RESP_ERR_EN to add the sticky resp_err output.
module cbus_axi_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 4,
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID = 0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic req_valid,
  input  logic req_is_write,
  input  logic [2:0] req_size,
  input  logic [31:0] req_addr,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic [DATA_WIDTH/8-1:0] req_strobe,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic resp_okay,
  output logic resp_last,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic busy,
`ifdef CBUS_AXI_RESP_ERR_EN
  output logic resp_err,
`endif
  cbus_axi_bridge_if.master axi
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
  state_t state, state_nx;
  logic [LEN_WIDTH-1:0] cnt;
  logic unused_ok;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) cnt <= '0;
    else if (state == AW) cnt <= '0;
    else if (axi.wvalid && axi.wready && !axi.wlast) cnt <= cnt + 1'b1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req_valid ? (req_is_write ? AW : AR) : IDLE;
      AR: state_nx = axi.arready ? R : AR;
      R: state_nx = (axi.rvalid && axi.rlast) ? IDLE : R;
      AW: state_nx = axi.awready ? W : AW;
      W: state_nx = (axi.wready && axi.wlast) ? B : W;
      B: state_nx = axi.bvalid ? IDLE : B;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    axi.arid = ID_WIDTH'(AXI_ID);
    axi.awid = ID_WIDTH'(AXI_ID);
    axi.wid = ID_WIDTH'(AXI_ID);
    axi.araddr = req_addr;
    axi.awaddr = req_addr;
    axi.arlen = req_len;
    axi.awlen = req_len;
    axi.arsize = req_size;
    axi.awsize = req_size;
    axi.arburst = 2'b01;
    axi.awburst = 2'b01;
    axi.arlock = '0;
    axi.awlock = '0;
    axi.arcache = '0;
    axi.awcache = '0;
    axi.arprot = '0;
    axi.awprot = '0;
    axi.arvalid = state == AR;
    axi.rready = state == R;
    axi.awvalid = state == AW;
    axi.wvalid = state == W;
    axi.bready = state == B;
    axi.wdata = req_data;
    axi.wstrb = req_strobe;
    axi.wlast = (state == W) && (cnt == req_len);
    resp_okay = (axi.rready && axi.rvalid) || (axi.wvalid && axi.wready);
    resp_last = (axi.rready && axi.rvalid && axi.rlast) || (axi.wvalid && axi.wready && axi.wlast);
    resp_data = axi.rdata;
    busy = state != IDLE;
  end
`ifdef CBUS_AXI_RESP_ERR_EN
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) resp_err <= 1'b0;
    else if ((axi.rready && axi.rvalid && axi.rresp != 2'b00) || (axi.bready && axi.bvalid && axi.bresp != 2'b00)) resp_err <= 1'b1;
`endif
  assign unused_ok = ^{axi.rid, axi.rresp, axi.bresp};
  // CBus must keep the request up until its final beat has been acknowledged
  a_req_held: assert property (@(posedge aclk) disable iff (!aresetn) (state inside {AR, R, AW, W}) |-> req_valid);
endmodule
